// File: rtl/m01_pkg.sv
// Shared types and elaboration-time helpers for the m01 burst address generator.
// Imported by the m01 signal blocks that size themselves from the burst geometry.
package m01_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } m01_gen_state_t;

  // log2 of a power-of-two burst size; used as the idx-to-byte-offset shift.
  function automatic int unsigned burst_shift(input int unsigned burst_bytes);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) == burst_bytes) s = i;
    end
    return s;
  endfunction

  // Beats-minus-one for 32-bit beats (the ARLEN rule).
  function automatic int unsigned arlen_of(input int unsigned burst_bytes);
    return burst_bytes / 4 - 1;
  endfunction

endpackage

// File: rtl/m01_burst_addr_gen_rise_detect.sv
// Registered rising-edge detector; rise is high while d is high and was low
// at the previous clock edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/m01_burst_addr_gen.sv
// Latches a base address on the first rise of transfer_done and issues
// NUM_BURSTS read-burst requests over a valid/ready address channel.
module m01_burst_addr_gen
  import m01_pkg::*;
#(
  parameter int unsigned BURST_BYTES = 64,
  parameter int unsigned NUM_BURSTS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        transfer_done,
  input  logic [31:0] ram_rd_data,
  input  logic        rearm,
  output logic        m_arvalid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  input  logic        m_arready,
  output logic [31:0] base_addr,
  output logic        align_err,
  output logic        gen_busy,
  output logic        gen_done
);

  localparam int unsigned SHIFT    = burst_shift(BURST_BYTES);
  localparam logic [7:0]  LAST_IDX = 8'(NUM_BURSTS - 1);
  localparam logic [31:0] LOW_MASK = 32'(BURST_BYTES - 1);

  m01_gen_state_t state_q, state_d;
  logic [7:0]     idx_q, idx_d;
  logic [31:0]    base_addr_q, base_addr_d;
  logic [31:0]    m_araddr_q, m_araddr_d;
  logic           m_arvalid_q, m_arvalid_d;
  logic           align_err_q, align_err_d;
  logic           gen_busy_q, gen_busy_d;
  logic           gen_done_q, gen_done_d;

  logic           start;
  logic [31:0]    aligned_base;
  logic [7:0]     idx_inc;

  rise_detect u_td_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (transfer_done),
    .rise (start)
  );

  assign aligned_base = ram_rd_data & ~LOW_MASK;
  assign idx_inc      = idx_q + 8'd1;

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_addr_d = base_addr_q;
    m_araddr_d  = m_araddr_q;
    m_arvalid_d = m_arvalid_q;
    align_err_d = align_err_q;
    gen_busy_d  = gen_busy_q;
    gen_done_d  = gen_done_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_addr_d = aligned_base;
          align_err_d = |(ram_rd_data & LOW_MASK);
          idx_d       = 8'd0;
          m_araddr_d  = aligned_base;
          m_arvalid_d = 1'b1;
          gen_busy_d  = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Address only advances on a handshake, so it is stable across stalls.
        if (m_arvalid_q && m_arready) begin
          if (idx_q == LAST_IDX) begin
            m_arvalid_d = 1'b0;
            gen_busy_d  = 1'b0;
            gen_done_d  = 1'b1;
            state_d     = DONE;
          end else begin
            idx_d      = idx_inc;
            m_araddr_d = base_addr_q + ({24'd0, idx_inc} << SHIFT);
          end
        end
      end
      DONE: begin
        if (rearm) begin
          gen_done_d  = 1'b0;
          align_err_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 8'd0;
      base_addr_q <= 32'd0;
      m_araddr_q  <= 32'd0;
      m_arvalid_q <= 1'b0;
      align_err_q <= 1'b0;
      gen_busy_q  <= 1'b0;
      gen_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_addr_q <= base_addr_d;
      m_araddr_q  <= m_araddr_d;
      m_arvalid_q <= m_arvalid_d;
      align_err_q <= align_err_d;
      gen_busy_q  <= gen_busy_d;
      gen_done_q  <= gen_done_d;
    end
  end

  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arlen   = 8'(arlen_of(BURST_BYTES));
  assign base_addr = base_addr_q;
  assign align_err = align_err_q;
  assign gen_busy  = gen_busy_q;
  assign gen_done  = gen_done_q;

endmodule

// File: tb/tb_m01_burst_addr_gen.sv
// Scoreboard bench for m01_burst_addr_gen: expected burst addresses are queued
// at each start and popped on every address handshake.
module tb_m01_burst_addr_gen;

  localparam int unsigned BB = 64;
  localparam int unsigned NB = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-geometry instance.
  logic        transfer_done, rearm, m_arready;
  logic [31:0] ram_rd_data;
  logic        m_arvalid, align_err, gen_busy, gen_done;
  logic [31:0] m_araddr, base_addr;
  logic [7:0]  m_arlen;

  // Minimal-geometry instance: one 4-byte burst.
  logic        s_transfer_done, s_rearm, s_arready;
  logic [31:0] s_ram_rd_data;
  logic        s_arvalid, s_align_err, s_busy, s_done;
  logic [31:0] s_araddr, s_base_addr;
  logic [7:0]  s_arlen;

  m01_burst_addr_gen #(.BURST_BYTES(BB), .NUM_BURSTS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .transfer_done(transfer_done), .ram_rd_data(ram_rd_data),
    .rearm(rearm), .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arready(m_arready), .base_addr(base_addr), .align_err(align_err),
    .gen_busy(gen_busy), .gen_done(gen_done)
  );

  m01_burst_addr_gen #(.BURST_BYTES(4), .NUM_BURSTS(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .transfer_done(s_transfer_done), .ram_rd_data(s_ram_rd_data),
    .rearm(s_rearm), .m_arvalid(s_arvalid), .m_araddr(s_araddr), .m_arlen(s_arlen),
    .m_arready(s_arready), .base_addr(s_base_addr), .align_err(s_align_err),
    .gen_busy(s_busy), .gen_done(s_done)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a start edge and queues the full expected address sequence.
  task automatic start_run(input logic [31:0] raw);
    logic [31:0] aligned;
    aligned     = raw & ~32'(BB - 1);
    for (int i = 0; i < int'(NB); i++) exp_q.push_back(aligned + 32'(i * int'(BB)));
    ram_rd_data   = raw;
    transfer_done = 1'b1;
    tick();
    check("start_valid", 32'(m_arvalid), 32'd1);
    check("start_busy", 32'(gen_busy), 32'd1);
    check("start_addr", m_araddr, aligned);
    check("base_addr", base_addr, aligned);
    check("align_err", 32'(align_err), 32'(raw[5:0] != 6'd0));
    check("arlen", 32'(m_arlen), 32'(BB / 4 - 1));
  endtask

  // Handshakes the rest of a run with 0..max_stall ready-low cycles per request.
  task automatic drain(input int max_stall, input int exp_cycles);
    int          cycles, hs, stall_left;
    logic        pre_v, pre_r, done;
    logic [31:0] pre_a;
    cycles     = 1;
    hs         = 0;
    done       = 1'b0;
    stall_left = int'($urandom_range(0, max_stall));
    for (int c = 0; c < 600 && !done; c++) begin
      if (m_arvalid && stall_left > 0) begin
        m_arready = 1'b0;
        stall_left--;
      end else begin
        m_arready = 1'b1;
      end
      pre_v = m_arvalid;
      pre_r = m_arready;
      pre_a = m_araddr;
      tick();
      cycles++;
      if (pre_v && pre_r) begin
        hs++;
        if (exp_q.size() == 0) check("hs_overflow", 32'(hs), 32'(NB));
        else check("hs_addr", pre_a, exp_q.pop_front());
        stall_left = int'($urandom_range(0, max_stall));
      end else if (pre_v) begin
        check("stall_addr", m_araddr, pre_a);
        check("stall_valid", 32'(m_arvalid), 32'd1);
      end
      if (gen_done) done = 1'b1;
    end
    if (!done) check("done_timeout", 32'(gen_done), 32'd1);
    check("hs_count", 32'(hs), 32'(NB));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    if (exp_cycles > 0) check("latency", 32'(cycles), 32'(exp_cycles));
    check("end_valid", 32'(m_arvalid), 32'd0);
    check("end_busy", 32'(gen_busy), 32'd0);
    m_arready = 1'b1;
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    check("rearm_done", 32'(gen_done), 32'd0);
    check("rearm_align", 32'(align_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    transfer_done = 1'b0; rearm = 1'b0; m_arready = 1'b1; ram_rd_data = 32'd0;
    s_transfer_done = 1'b0; s_rearm = 1'b0; s_arready = 1'b1; s_ram_rd_data = 32'd0;
    #1;
    check("rst_valid", 32'(m_arvalid), 32'd0);
    check("rst_busy", 32'(gen_busy), 32'd0);
    check("rst_done", 32'(gen_done), 32'd0);
    check("rst_align", 32'(align_err), 32'd0);
    check("rst_araddr", m_araddr, 32'd0);
    check("rst_base", base_addr, 32'd0);
    check("rst_arlen", 32'(m_arlen), 32'd15);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Aligned base, ready always high: one burst per cycle.
    start_run(32'h4580_0000);
    drain(0, int'(NB) + 1);
    check("t1_done", 32'(gen_done), 32'd1);

    // transfer_done stays high through rearm: no restart.
    do_rearm();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_no_valid", 32'(m_arvalid), 32'd0);
      check("held_no_busy", 32'(gen_busy), 32'd0);
    end
    transfer_done = 1'b0;
    tick();

    // Random stalls; a new base from the fresh rise.
    start_run(32'h1234_5600);
    drain(5, 0);
    do_rearm();
    transfer_done = 1'b0;
    tick();

    // Misaligned base near the top of the address space wraps to zero.
    start_run(32'hFFFF_FFC5);
    check("wrap_second", exp_q[1], 32'h0000_0000);
    drain(2, 0);
    check("wrap_align_sticky", 32'(align_err), 32'd1);
    do_rearm();
    transfer_done = 1'b0;
    tick();

    // Reset while the fifth request is stalled.
    start_run(32'h1000_0000);
    m_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = m_araddr;
      tick();
      check("pre_rst_hs", a, exp_q.pop_front());
    end
    m_arready = 1'b0;
    tick();
    check("fifth_addr", m_araddr, exp_q[0]);
    check("fifth_valid", 32'(m_arvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_arvalid), 32'd0);
    check("mid_rst_busy", 32'(gen_busy), 32'd0);
    check("mid_rst_araddr", m_araddr, 32'd0);
    check("mid_rst_base", base_addr, 32'd0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    start_run(32'h1000_0000);
    drain(0, int'(NB) + 1);

    // Single 4-byte burst instance.
    s_ram_rd_data   = 32'h0000_1237;
    s_transfer_done = 1'b1;
    tick();
    check("s_valid", 32'(s_arvalid), 32'd1);
    check("s_addr", s_araddr, 32'h0000_1234);
    check("s_arlen", 32'(s_arlen), 32'd0);
    check("s_align", 32'(s_align_err), 32'd1);
    tick();
    check("s_done", 32'(s_done), 32'd1);
    check("s_valid_off", 32'(s_arvalid), 32'd0);
    tick();
    check("s_one_only", 32'(s_arvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/m01_burst_addr_gen.md
# m01_burst_addr_gen

Consumes the base-address fetch result from the BRAM reader stage. On the first rising edge of that stage's transfer-done flag, it latches the 32-bit base address. It then issues a fixed sequence of read-burst requests over a valid/ready address channel toward the m01 master. Final completion is reported with a level `gen_done`.

## Interface
Parameters:
- `BURST_BYTES`, 64: bytes per burst; power of two, 4..1024.
- `NUM_BURSTS`, 16: bursts per run, 1..256.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `transfer_done`  in  1  done flag from the base-address reader; level, may stay high.
- `ram_rd_data`  in  32  base address from BRAM; valid whenever `transfer_done` is high.
- `rearm`  in  1  single-cycle request to return from DONE to IDLE.
- `m_arvalid`  out  1  burst request valid.
- `m_araddr`  out  32  burst start address.
- `m_arlen`  out  8  beats minus one; constant `BURST_BYTES/4 - 1`.
- `m_arready`  in  1  downstream accepts the request.
- `base_addr`  out  32  latched base address, after alignment.
- `align_err`  out  1  sticky; latched base had nonzero bits below `log2(BURST_BYTES)`.
- `gen_busy`  out  1  high in ISSUE.
- `gen_done`  out  1  high in DONE.

## Operation
- Edge detect: `td_q` registers `transfer_done` and resets to 0. A start is `transfer_done & ~td_q`.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - On start, latch `base_addr = ram_rd_data` with bits `[log2(BURST_BYTES)-1:0]` forced to 0.
  - Set `align_err` if any of those bits were 1.
  - Clear `idx`, then go to ISSUE.
  - Without a start, all outputs hold.
- ISSUE:
  - `m_arvalid = 1` and `m_araddr = base_addr + idx*BURST_BYTES`, computed modulo 2^32 so it wraps past 0xFFFF_FFFF silently.
  - On `m_arvalid & m_arready`: if `idx == NUM_BURSTS-1`, go to DONE; otherwise `idx++`.
  - `idx` is 8 bits wide.
- DONE:
  - `m_arvalid = 0` and `gen_done = 1`.
  - `rearm` moves the FSM to IDLE and clears `align_err`.
  - `base_addr` keeps its value.
- Start edges seen in ISSUE or DONE are ignored and are not queued.
- `rearm` in IDLE or ISSUE is ignored.
- `transfer_done` held high across a rearm does not restart the FSM. A new low-to-high transition is required.
- Reset mid-ISSUE:
  - The FSM and `td_q` return to their reset values immediately.
  - The in-flight request is dropped; no handshake is completed.
  - After reset, a `transfer_done` that is already high counts as a start on the first clock, because `td_q` is 0.

## Timing
- Reset values:
  - `m_arvalid`, `gen_busy`, `gen_done`, `align_err` = 0.
  - `m_araddr`, `base_addr` = 0.
  - `m_arlen` = constant.
  - FSM = IDLE.
- All outputs are registered, with no combinational path from `m_arready` to any output.
- Start sampled at edge N: `m_arvalid = 1`, `gen_busy = 1` and the first address are visible after edge N, i.e. during cycle N+1.
- Valid/ready rules:
  - While `m_arvalid = 1` and `m_arready = 0`, `m_araddr` is stable.
  - `m_arvalid` never drops without a handshake, except on reset.
- Back-to-back: with a handshake at edge K, the next address is presented from K+1 with `m_arvalid` kept high. Throughput is one burst per cycle when `m_arready` is held high.
- Final handshake at edge K: `m_arvalid = 0`, `gen_busy = 0`, `gen_done = 1` from K+1.
- Rearm at edge R: `gen_done = 0` from R+1, and a new start is accepted at edge R+1 at the earliest.
- With `m_arready = 1` constantly, start-to-`gen_done` latency is `NUM_BURSTS + 1` cycles.

## Structure
- Shared package `m01_pkg` holds:
  - State enum `m01_gen_state_t` (IDLE, ISSUE, DONE).
  - Function `burst_shift(BURST_BYTES)` returning the log2.
  - Localparam rule `ARLEN = BURST_BYTES/4 - 1`.
- One natural sub-module: `rise_detect`, a registered rising-edge detector with asynchronous active-low reset; it is reused by other m01 signal blocks.
- Address generation is an adder `base_addr + (idx << burst_shift)`, registered into `m_araddr` on state entry and on each handshake.

## Test plan
- `ram_rd_data = 0x4580_0000`, `transfer_done` rises, `m_arready = 1` -> 16 requests at 0x4580_0000, 0x4580_0040 … 0x4580_03C0, each with `m_arlen = 15`; `gen_done` is high 17 cycles after the start edge; `align_err = 0`.
- Random `m_arready` stalls of 0–5 cycles -> `m_araddr` is stable during every stall, there are no duplicate or skipped addresses, and the handshake count is exactly 16.
- `ram_rd_data = 0xFFFF_FFC5` -> `base_addr = 0xFFFF_FFC0`, `align_err = 1`, second address is 0x0000_0000 (wrap), run completes normally.
- `transfer_done` held high through DONE and `rearm` -> FSM stays in IDLE; a low pulse followed by a rise starts a new run using the new `ram_rd_data`.
- `rst_n` asserted during the 5th request while `m_arready = 0` -> all outputs take reset values immediately; after release with `transfer_done` high, the run restarts from `idx = 0`.
- `NUM_BURSTS = 1`, `BURST_BYTES = 4` -> exactly one request with `m_arlen = 0`; `gen_done` is set the cycle after its handshake.
